// File: rtl/alu_pkg.sv
// Shared opcode definitions for the datapath ALU and anything that decodes
// ALU instructions.
package alu_pkg;

   localparam int IWIDTH = 4;

   localparam logic [3:0] ALU_NOT  = 4'h0;
   localparam logic [3:0] ALU_XOR  = 4'h1;
   localparam logic [3:0] ALU_OR   = 4'h2;
   localparam logic [3:0] ALU_AND  = 4'h3;
   localparam logic [3:0] ALU_SUB  = 4'h4;
   localparam logic [3:0] ALU_ADD  = 4'h5;
   localparam logic [3:0] ALU_RR   = 4'h6;
   localparam logic [3:0] ALU_RL   = 4'h7;
   localparam logic [3:0] ALU_DEC  = 4'h8;
   localparam logic [3:0] ALU_INC  = 4'h9;
   localparam logic [3:0] ALU_PASB = 4'hA;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by ADD, SUB, INC and DEC.
// With i_sub set, i_cin acts as borrow-in and o_cout reports borrow-out.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   logic [WIDTH:0] w_ext;
   logic [WIDTH:0] w_cinExt;

   assign w_cinExt = {{WIDTH{1'b0}}, i_cin};

   // One extra bit: it holds the carry for add and goes high on underflow for subtract.
   always_comb begin
      if (i_sub) begin
         w_ext = {1'b0, i_a} - {1'b0, i_b} - w_cinExt;
      end else begin
         w_ext = {1'b0, i_a} + {1'b0, i_b} + w_cinExt;
      end
   end

   assign o_sum  = w_ext[WIDTH-1:0];
   assign o_cout = w_ext[WIDTH];

endmodule

// File: rtl/alu.sv
// Registered 16-opcode ALU: operand/opcode sampled at a rising edge produce
// result and carry/borrow flags visible right after that edge.
module alu #(
   parameter int WIDTH  = 8,
   parameter int IWIDTH = alu_pkg::IWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IWIDTH-1:0] instr,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic              alu_c_in,
   input  logic              alu_b_in,
   output logic [WIDTH-1:0]  alu_out,
   output logic              alu_c_out,
   output logic              alu_b_out
);

   import alu_pkg::*;

   logic [WIDTH-1:0] w_opB;
   logic             w_carryIn;
   logic             w_sub;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_nextOut;
   logic             w_nextC;
   logic             w_nextB;

   logic [WIDTH-1:0] r_out;
   logic             r_c;
   logic             r_b;

   // INC/DEC reuse the adder with a zero B operand and a forced carry/borrow of one.
   always_comb begin
      w_opB     = in_b;
      w_carryIn = 1'b0;
      w_sub     = 1'b0;
      case (instr)
         ALU_ADD: w_carryIn = alu_c_in;
         ALU_SUB: begin
            w_carryIn = alu_b_in;
            w_sub     = 1'b1;
         end
         ALU_INC: begin
            w_opB     = '0;
            w_carryIn = 1'b1;
         end
         ALU_DEC: begin
            w_opB     = '0;
            w_carryIn = 1'b1;
            w_sub     = 1'b1;
         end
         default: ;
      endcase
   end

   alu_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .i_a    (in_a),
      .i_b    (w_opB),
      .i_cin  (w_carryIn),
      .i_sub  (w_sub),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Flags default low so opcodes that do not produce a flag clear it.
   always_comb begin
      w_nextOut = '0;
      w_nextC   = 1'b0;
      w_nextB   = 1'b0;
      case (instr)
         ALU_NOT:  w_nextOut = ~in_a;
         ALU_XOR:  w_nextOut = in_a ^ in_b;
         ALU_OR:   w_nextOut = in_a | in_b;
         ALU_AND:  w_nextOut = in_a & in_b;
         ALU_SUB, ALU_DEC: begin
            w_nextOut = w_sum;
            w_nextB   = w_cout;
         end
         ALU_ADD, ALU_INC: begin
            w_nextOut = w_sum;
            w_nextC   = w_cout;
         end
         ALU_RR:   w_nextOut = {in_a[0], in_a[WIDTH-1:1]};
         ALU_RL:   w_nextOut = {in_a[WIDTH-2:0], in_a[WIDTH-1]};
         ALU_PASB: w_nextOut = in_b;
         default:  w_nextOut = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
         r_c   <= 1'b0;
         r_b   <= 1'b0;
      end else begin
         r_out <= w_nextOut;
         r_c   <= w_nextC;
         r_b   <= w_nextB;
      end
   end

   assign alu_out   = r_out;
   assign alu_c_out = r_c;
   assign alu_b_out = r_b;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU: directed vectors plus random
// stimulus compared against an arithmetic reference model.
module tb_alu;

   logic       clk;
   logic       rst;
   logic [3:0] instr;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       alu_c_in;
   logic       alu_b_in;
   logic [7:0] alu_out;
   logic       alu_c_out;
   logic       alu_b_out;

   int testCount = 0;
   int failCount = 0;

   alu #(
      .WIDTH  (8),
      .IWIDTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .in_a      (in_a),
      .in_b      (in_b),
      .alu_c_in  (alu_c_in),
      .alu_b_in  (alu_b_in),
      .alu_out   (alu_out),
      .alu_c_out (alu_c_out),
      .alu_b_out (alu_b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model from the opcode table, returns {cout, bout, out}.
   function automatic logic [9:0] refModel(int op, int a, int b, int ci, int bi);
      int r;
      int co;
      int bo;
      r  = 0;
      co = 0;
      bo = 0;
      case (op)
         0:  r = 255 - a;
         1:  r = a ^ b;
         2:  r = a | b;
         3:  r = a & b;
         4:  begin r = a - b - bi; bo = (a < b + bi) ? 1 : 0; end
         5:  begin r = a + b + ci; co = (r > 255) ? 1 : 0; end
         6:  r = (a / 2) + (a % 2) * 128;
         7:  r = (a * 2) % 256 + (a / 128);
         8:  begin r = a - 1; bo = (a == 0) ? 1 : 0; end
         9:  begin r = a + 1; co = (a == 255) ? 1 : 0; end
         10: r = b;
         default: r = 0;
      endcase
      return {co[0], bo[0], r[7:0]};
   endfunction

   // Drive one operation, then land just after the edge that registers it.
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic ci, input logic bi);
      instr    = op;
      in_a     = a;
      in_b     = b;
      alu_c_in = ci;
      alu_b_in = bi;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(4'h5, 8'hFF, 8'h01, 1'b0, 1'b0);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== 10'b0) begin
         failCount++;
         $display("[TB] FAIL reset_initial: got out=%h c=%b b=%b, want out=00 c=0 b=0", alu_out, alu_c_out, alu_b_out);
      end
      rst = 1'b0;
      applyStimulus(4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== {8'hFF, 2'b00}) begin
         failCount++;
         $display("[TB] FAIL reset_pre_not: got out=%h c=%b b=%b, want out=FF c=0 b=0", alu_out, alu_c_out, alu_b_out);
      end
      rst = 1'b1;
      applyStimulus(4'h5, 8'hFF, 8'h01, 1'b0, 1'b0);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== 10'b0) begin
         failCount++;
         $display("[TB] FAIL reset_override: got out=%h c=%b b=%b, want out=00 c=0 b=0", alu_out, alu_c_out, alu_b_out);
      end
      rst = 1'b0;
      applyStimulus(4'h5, 8'hFF, 8'h01, 1'b0, 1'b0);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== {8'h00, 2'b10}) begin
         failCount++;
         $display("[TB] FAIL reset_release_add: got out=%h c=%b b=%b, want out=00 c=1 b=0", alu_out, alu_c_out, alu_b_out);
      end
   endtask

   // Vector packing: {op[31:28], a[27:20], b[19:12], ci[11], bi[10], out[9:2], c[1], b[0]}
   task automatic test_logic();
      logic [31:0] vecs [$];
      logic [31:0] v;
      vecs.push_back({4'h1, 8'hFF, 8'hAA, 2'b00, 8'h55, 2'b00});
      vecs.push_back({4'h2, 8'h02, 8'h0A, 2'b00, 8'h0A, 2'b00});
      vecs.push_back({4'h3, 8'hFF, 8'hAA, 2'b00, 8'hAA, 2'b00});
      vecs.push_back({4'h0, 8'h00, 8'h5A, 2'b11, 8'hFF, 2'b00});
      vecs.push_back({4'h0, 8'hEE, 8'h00, 2'b00, 8'h11, 2'b00});
      foreach (vecs[i]) begin
         v = vecs[i];
         applyStimulus(v[31:28], v[27:20], v[19:12], v[11], v[10]);
         testCount++;
         if ({alu_out, alu_c_out, alu_b_out} !== v[9:0]) begin
            failCount++;
            $display("[TB] FAIL logic[%0d]: got out=%h c=%b b=%b, want out=%h c=%b b=%b",
                     i, alu_out, alu_c_out, alu_b_out, v[9:2], v[1], v[0]);
         end
      end
   endtask

   task automatic test_add_sub();
      logic [31:0] vecs [$];
      logic [31:0] v;
      vecs.push_back({4'h5, 8'h04, 8'h02, 2'b00, 8'h06, 2'b00});
      vecs.push_back({4'h5, 8'h04, 8'h02, 2'b10, 8'h07, 2'b00});
      vecs.push_back({4'h5, 8'h0A, 8'h0B, 2'b10, 8'h16, 2'b00});
      vecs.push_back({4'h5, 8'hFF, 8'h01, 2'b01, 8'h00, 2'b10});
      vecs.push_back({4'h4, 8'h04, 8'h02, 2'b00, 8'h02, 2'b00});
      vecs.push_back({4'h4, 8'h04, 8'h02, 2'b01, 8'h01, 2'b00});
      vecs.push_back({4'h4, 8'h0A, 8'h0B, 2'b01, 8'hFE, 2'b01});
      vecs.push_back({4'h4, 8'h03, 8'h1F, 2'b11, 8'hE3, 2'b01});
      foreach (vecs[i]) begin
         v = vecs[i];
         applyStimulus(v[31:28], v[27:20], v[19:12], v[11], v[10]);
         testCount++;
         if ({alu_out, alu_c_out, alu_b_out} !== v[9:0]) begin
            failCount++;
            $display("[TB] FAIL addsub[%0d]: got out=%h c=%b b=%b, want out=%h c=%b b=%b",
                     i, alu_out, alu_c_out, alu_b_out, v[9:2], v[1], v[0]);
         end
      end
   endtask

   task automatic test_rot_inc_dec();
      logic [31:0] vecs [$];
      logic [31:0] v;
      vecs.push_back({4'h6, 8'h0A, 8'h00, 2'b11, 8'h05, 2'b00});
      vecs.push_back({4'h7, 8'h0A, 8'h00, 2'b11, 8'h14, 2'b00});
      vecs.push_back({4'h6, 8'h01, 8'h00, 2'b00, 8'h80, 2'b00});
      vecs.push_back({4'h7, 8'h80, 8'h00, 2'b00, 8'h01, 2'b00});
      vecs.push_back({4'h8, 8'h70, 8'h00, 2'b00, 8'h6F, 2'b00});
      vecs.push_back({4'h8, 8'h00, 8'h00, 2'b00, 8'hFF, 2'b01});
      vecs.push_back({4'h9, 8'h20, 8'h00, 2'b00, 8'h21, 2'b00});
      vecs.push_back({4'h9, 8'hFF, 8'h00, 2'b00, 8'h00, 2'b10});
      foreach (vecs[i]) begin
         v = vecs[i];
         applyStimulus(v[31:28], v[27:20], v[19:12], v[11], v[10]);
         testCount++;
         if ({alu_out, alu_c_out, alu_b_out} !== v[9:0]) begin
            failCount++;
            $display("[TB] FAIL rotincdec[%0d]: got out=%h c=%b b=%b, want out=%h c=%b b=%b",
                     i, alu_out, alu_c_out, alu_b_out, v[9:2], v[1], v[0]);
         end
      end
   endtask

   task automatic test_pasb_reserved();
      applyStimulus(4'hA, 8'h33, 8'h00, 1'b1, 1'b1);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== 10'b0) begin
         failCount++;
         $display("[TB] FAIL pasb_zero: got out=%h c=%b b=%b, want out=00 c=0 b=0", alu_out, alu_c_out, alu_b_out);
      end
      in_b = 8'h12;
      #2;
      testCount++;
      if (alu_out !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL pasb_latency: got out=%h before edge, want 00", alu_out);
      end
      @(posedge clk);
      #1;
      testCount++;
      if (alu_out !== 8'h12) begin
         failCount++;
         $display("[TB] FAIL pasb_follow: got out=%h, want 12", alu_out);
      end
      for (int op = 11; op <= 15; op++) begin
         applyStimulus(op[3:0], 8'hFF, 8'hFF, 1'b1, 1'b1);
         testCount++;
         if ({alu_out, alu_c_out, alu_b_out} !== 10'b0) begin
            failCount++;
            $display("[TB] FAIL reserved_%0h: got out=%h c=%b b=%b, want out=00 c=0 b=0",
                     op, alu_out, alu_c_out, alu_b_out);
         end
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(4'h5, 8'hFF, 8'h01, 1'b0, 1'b0);
      applyStimulus(4'h1, 8'h0F, 8'hF0, 1'b1, 1'b1);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== {8'hFF, 2'b00}) begin
         failCount++;
         $display("[TB] FAIL carry_cleared: got out=%h c=%b b=%b, want out=FF c=0 b=0", alu_out, alu_c_out, alu_b_out);
      end
      applyStimulus(4'h4, 8'h00, 8'h01, 1'b0, 1'b0);
      applyStimulus(4'h9, 8'h05, 8'h00, 1'b1, 1'b1);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== {8'h06, 2'b00}) begin
         failCount++;
         $display("[TB] FAIL borrow_cleared: got out=%h c=%b b=%b, want out=06 c=0 b=0", alu_out, alu_c_out, alu_b_out);
      end
      applyStimulus(4'h9, 8'h05, 8'h00, 1'b1, 1'b1);
      testCount++;
      if ({alu_out, alu_c_out, alu_b_out} !== {8'h06, 2'b00}) begin
         failCount++;
         $display("[TB] FAIL hold_stable: got out=%h c=%b b=%b, want out=06 c=0 b=0", alu_out, alu_c_out, alu_b_out);
      end
   endtask

   task automatic test_random();
      logic [9:0] expected;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic       bi;
      for (int n = 0; n < 400; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         ci = 1'($urandom_range(0, 1));
         bi = 1'($urandom_range(0, 1));
         if (n % 16 == 0) a = 8'hFF;
         if (n % 16 == 1) a = 8'h00;
         expected = refModel(int'(op), int'(a), int'(b), int'(ci), int'(bi));
         applyStimulus(op, a, b, ci, bi);
         testCount++;
         if ({alu_c_out, alu_b_out, alu_out} !== expected) begin
            failCount++;
            $display("[TB] FAIL random[%0d] op=%h a=%h b=%h ci=%b bi=%b: got out=%h c=%b b=%b, want out=%h c=%b b=%b",
                     n, op, a, b, ci, bi, alu_out, alu_c_out, alu_b_out, expected[7:0], expected[9], expected[8]);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      instr    = 4'h0;
      in_a     = 8'h00;
      in_b     = 8'h00;
      alu_c_in = 1'b0;
      alu_b_in = 1'b0;
      test_reset();
      test_logic();
      test_add_sub();
      test_rot_inc_dec();
      test_pasb_reserved();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
